// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - PC-indexed saturating-counter branch predictor with registered resolve stage
// Optional statistics counters enabled by defining BP_STATS_EN.
module branch_predict_unit #(
    parameter int PC_W       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic               pred_taken,
    input  logic               res_valid,
    input  logic [PC_W-1:0]    res_pc,
    input  logic [5:0]         OpCode,
    input  logic [4:0]         rt,
    input  logic signed [31:0] RD1,
    input  logic signed [31:0] RD2,
    input  logic               res_pred,
    output logic               out_valid,
    output logic               out_is_branch,
    output logic               out_taken,
    output logic               wrong_taken,
    output logic               wrong_not_taken,
    output logic [PC_W-1:0]    out_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int TABLE_SIZE = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    logic [CNT_BITS-1:0]   table_q [TABLE_SIZE];
    logic [CNT_BITS-1:0]   table_d [TABLE_SIZE];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] res_idx;
    logic [CNT_BITS-1:0]   cur_cnt;
    logic                  is_branch;
    logic                  taken;
    logic                  upd;
    logic                  unused_fetch;

    logic            out_valid_q, out_valid_d;
    logic            out_is_branch_q, out_is_branch_d;
    logic            out_taken_q, out_taken_d;
    logic            wrong_taken_q, wrong_taken_d;
    logic            wrong_not_taken_q, wrong_not_taken_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;

    assign fetch_idx    = fetch_pc[INDEX_BITS+1:2];
    assign res_idx      = res_pc[INDEX_BITS+1:2];
    assign unused_fetch = ^fetch_pc;

    // Read of current state only: an update in this cycle becomes visible next cycle.
    assign pred_taken = table_q[fetch_idx][CNT_BITS-1];

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (OpCode)
            6'b000100: begin is_branch = 1'b1; taken = (RD1 == RD2); end
            6'b000101: begin is_branch = 1'b1; taken = (RD1 != RD2); end
            6'b000110: begin is_branch = 1'b1; taken = (RD1 <= 32'sd0); end
            6'b000111: begin is_branch = 1'b1; taken = (RD1 > 32'sd0); end
            6'b000001: begin
                if (rt == 5'b00001) begin
                    is_branch = 1'b1;
                    taken     = (RD1 >= 32'sd0);
                end else if (rt == 5'b00000) begin
                    is_branch = 1'b1;
                    taken     = (RD1 < 32'sd0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        upd               = res_valid & is_branch;
        out_valid_d       = res_valid;
        out_is_branch_d   = upd;
        out_taken_d       = upd & taken;
        wrong_taken_d     = upd & res_pred & ~taken;
        wrong_not_taken_d = upd & ~res_pred & taken;
        out_pc_d          = res_pc;
    end

    always_comb begin
        table_d = table_q;
        cur_cnt = table_q[res_idx];
        if (upd) begin
            if (taken && cur_cnt != CNT_MAX)
                table_d[res_idx] = cur_cnt + CNT_BITS'(1);
            else if (!taken && cur_cnt != '0)
                table_d[res_idx] = cur_cnt - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_SIZE; i++)
                table_q[i] <= CNT_WEAK_NT;
            out_valid_q       <= 1'b0;
            out_is_branch_q   <= 1'b0;
            out_taken_q       <= 1'b0;
            wrong_taken_q     <= 1'b0;
            wrong_not_taken_q <= 1'b0;
            out_pc_q          <= '0;
        end else begin
            table_q           <= table_d;
            out_valid_q       <= out_valid_d;
            out_is_branch_q   <= out_is_branch_d;
            out_taken_q       <= out_taken_d;
            wrong_taken_q     <= wrong_taken_d;
            wrong_not_taken_q <= wrong_not_taken_d;
            out_pc_q          <= out_pc_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_is_branch   = out_is_branch_q;
    assign out_taken       = out_taken_q;
    assign wrong_taken     = wrong_taken_q;
    assign wrong_not_taken = wrong_not_taken_q;
    assign out_pc          = out_pc_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd && stat_branches_q != 32'hFFFF_FFFF)
            stat_branches_d = stat_branches_q + 32'd1;
        if ((wrong_taken_d || wrong_not_taken_d) && stat_mispredicts_q != 32'hFFFF_FFFF)
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch resolver.
- Adds a PC-indexed table of saturating counters for fetch-time taken/not-taken prediction.
- Resolves BEQ/BNE/BLEZ/BGTZ/BGEZ/BLTZ in a registered resolve stage, flags mispredictions, and trains the table.
- Sits between the fetch PC logic (lookup) and decode/register-read (resolve).

Parameters:
- PC_W, 32, PC width in bits.
- INDEX_BITS, 6, table index width; table holds 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- CNT_BITS, 2, saturating counter width (>=1); predict taken when counter MSB = 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_pc  in  PC_W  PC used for lookup.
- pred_taken  out  1  combinational prediction for fetch_pc.
- res_valid  in  1  resolve request this cycle.
- res_pc  in  PC_W  PC of the branch being resolved.
- OpCode  in  6  instruction opcode.
- rt  in  5  rt field (selects BGEZ/BLTZ under opcode 000001).
- RD1, RD2  in  32 signed  register operands.
- res_pred  in  1  prediction that was made for this branch at fetch.
- out_valid  out  1  registered; resolved result present.
- out_is_branch  out  1  registered; the instruction was a recognised conditional branch.
- out_taken  out  1  registered actual outcome.
- wrong_taken  out  1  registered; predicted taken, actually not taken.
- wrong_not_taken  out  1  registered; predicted not taken, actually taken.
- out_pc  out  PC_W  registered copy of res_pc.

Behaviour:
- Decode (combinational, into the resolve stage):
  - 000100 BEQ: RD1==RD2.
  - 000101 BNE: RD1!=RD2.
  - 000110 BLEZ: RD1<=0.
  - 000111 BGTZ: RD1>0.
  - 000001 with rt=00001 BGEZ: RD1>=0.
  - 000001 with rt=00000 BLTZ: RD1<0.
  - All comparisons are signed.
  - Any other opcode or rt: is_branch=0, taken=0.
- Latency: exactly 1 cycle. The resolve request sampled at edge N appears on out_* after edge N.
- out_valid = res_valid registered. No backpressure; one resolve accepted per cycle.
- out_is_branch, out_taken, wrong_* and out_pc are registered every cycle.
- When res_valid=0, all of out_is_branch, out_taken, wrong_taken and wrong_not_taken register as 0.
- Mispredict flags:
  - wrong_taken = valid & is_branch & res_pred & ~taken.
  - wrong_not_taken = valid & is_branch & ~res_pred & taken.
  - The two flags are mutually exclusive.
- Table update at the same edge that captures the result, only when res_valid & is_branch:
  - taken: counter increments, saturating at 2^CNT_BITS-1.
  - not taken: counter decrements, saturating at 0.
  - Non-branches never modify the table.
- Prediction read: pred_taken = MSB of table[fetch_pc index]. This is a pure combinational read of the current state.
- Same-index collision: fetch reads the pre-update value in the cycle of the update. No bypass; the new value is visible from the next cycle.
- Aliasing: different PCs with an equal index share an entry. This is intended.
- Reset (synchronous):
  - All table entries set to weakly not-taken, 2^(CNT_BITS-1)-1 (01 for 2 bits).
  - out_valid, out_is_branch, out_taken, wrong_taken and wrong_not_taken set to 0; out_pc set to 0.
- rst asserted together with res_valid: reset wins; no update, outputs 0.
- Reset mid-stream discards the in-flight result.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds output ports stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on each res_valid & is_branch.
  - stat_mispredicts increments when (wrong_taken | wrong_not_taken) would be registered.
  - Both counters update at the same edge as the table, saturate at 0xFFFFFFFF, and are cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x40 -> pred_taken=0; table entry reads 01; all out_* =0.
- res_valid, res_pc=0x40, BEQ, RD1=RD2=5, res_pred=0 -> next cycle out_taken=1, wrong_not_taken=1; after 2 such resolves the entry is 11 and pred_taken=1 for fetch_pc=0x40. A third taken keeps it at 11 (saturation).
- BLTZ (OpCode=000001, rt=0), RD1=-1, res_pred=1 -> out_taken=1, no mispredict. BGEZ rt=1, RD1=-1, res_pred=1 -> out_taken=0, wrong_taken=1.
- OpCode=000001, rt=00010, and OpCode=100011 (LW) with res_valid=1 -> out_valid=1, out_is_branch=0, wrong_*=0, table unchanged.
- fetch_pc=res_pc=0x80 in the update cycle (entry 01, taken) -> pred_taken=0 that cycle, 1 the next cycle. PC 0x180 with INDEX_BITS=6 aliases to entry 0x20 -> shares the prediction.
- rst asserted with res_valid and a taken branch -> no table change, out_valid=0 next cycle. With BP_STATS_EN: 3 branches, 1 mispredict -> stat_branches=3, stat_mispredicts=1; rst clears both.
